// File: rtl/audio_system_key_pkg.sv
// Shared constants and helpers for the push-button debounce path.
package audio_system_key_pkg;

  localparam int unsigned KEY_DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int unsigned KEY_WIDTH_DEFAULT           = 4;

  // Counter width able to hold 0..cycles; never narrower than one bit.
  function automatic int unsigned key_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/audio_system_key_debounce_cell.sv
// Single-key debounce: two-flop synchroniser, stability counter, stable level
// register and registered press/release strobes.
module audio_system_key_debounce_cell
  import audio_system_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_clean,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned      CNT_W    = key_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             REL_LVL  = ACTIVE_LOW;
  localparam logic             PRS_LVL  = ~ACTIVE_LOW;

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable_nxt;
  logic             press_nxt;
  logic             release_nxt;

  // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES edges.
  always_comb begin
    cnt_nxt     = '0;
    stable_nxt  = stable;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (sync2 != stable) begin
      if (cnt == CNT_LAST) begin
        stable_nxt  = sync2;
        press_nxt   = (sync2 == PRS_LVL);
        release_nxt = (sync2 == REL_LVL);
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1         <= REL_LVL;
      sync2         <= REL_LVL;
      stable        <= REL_LVL;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= key_raw;
      sync2         <= sync1;
      stable        <= stable_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  assign key_clean = stable;

endmodule

// File: rtl/audio_system_key_debounce.sv
// Debounces the push-button vector for the key PIO and produces per-key
// press/release strobes for local control logic.
module audio_system_key_debounce
  import audio_system_key_pkg::*;
#(
  parameter int unsigned WIDTH           = KEY_WIDTH_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] keys_raw,
  output logic [WIDTH-1:0] keys_clean,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    audio_system_key_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_cell (
      .clk           (clk),
      .reset         (reset),
      .key_raw       (keys_raw[i]),
      .key_clean     (keys_clean[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_audio_system_key_debounce.sv
// Bench for audio_system_key_debounce: one active-low and one active-high
// instance, checked each cycle against a sample-history reference model.
module tb_audio_system_key_debounce;

  localparam int unsigned DB   = 8;
  localparam int          HMAX = 4096;

  logic       clk;
  logic       reset;
  logic [3:0] raw_a, clean_a, press_a, rel_a;
  logic [3:0] raw_b, clean_b, press_b, rel_b;

  int errors = 0;
  int checks = 0;

  // Model: raw samples taken at every edge since reset, and expected outputs.
  logic [3:0] hist [2][HMAX];
  int         hlen [2];
  logic [3:0] exp_clean [2];
  logic [3:0] exp_press [2];
  logic [3:0] exp_rel   [2];

  audio_system_key_debounce #(
    .WIDTH(4), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .keys_raw(raw_a),
    .keys_clean(clean_a), .press_pulse(press_a), .release_pulse(rel_a)
  );

  audio_system_key_debounce #(
    .WIDTH(4), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .keys_raw(raw_b),
    .keys_clean(clean_b), .press_pulse(press_b), .release_pulse(rel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rel_lvl(input int d);
    return (d == 0) ? 4'hF : 4'h0;
  endfunction

  function automatic logic [3:0] get_s(input int d, input int idx);
    if (idx < 0) return rel_lvl(d);
    return hist[d][idx];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      hlen[d]      = 0;
      exp_clean[d] = rel_lvl(d);
      exp_press[d] = '0;
      exp_rel[d]   = '0;
    end
  endtask

  // A key's level flips when the samples taken 2..DB+1 edges ago all disagree with it.
  task automatic model_edge(input int d, input logic [3:0] raw);
    logic [3:0] s;
    logic [3:0] rl;
    logic       flip;
    exp_press[d] = '0;
    exp_rel[d]   = '0;
    rl = rel_lvl(d);
    if (reset) begin
      hlen[d]      = 0;
      exp_clean[d] = rl;
    end else begin
      if (hlen[d] >= HMAX) begin
        errors++;
        $display("FAIL model_history overflow observed=%0d required<%0d", hlen[d], HMAX);
        $fatal(1);
      end
      hist[d][hlen[d]] = raw;
      hlen[d]++;
      for (int k = 0; k < 4; k++) begin
        flip = 1'b1;
        for (int j = 2; j <= int'(DB) + 1; j++) begin
          s = get_s(d, hlen[d] - 1 - j);
          if (s[k] == exp_clean[d][k]) flip = 1'b0;
        end
        if (flip) begin
          exp_clean[d][k] = ~exp_clean[d][k];
          if (exp_clean[d][k] == rl[k]) exp_rel[d][k] = 1'b1;
          else                          exp_press[d][k] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_model();
    chk("a_clean",   clean_a, exp_clean[0]);
    chk("a_press",   press_a, exp_press[0]);
    chk("a_release", rel_a,   exp_rel[0]);
    chk("b_clean",   clean_b, exp_clean[1]);
    chk("b_press",   press_b, exp_press[1]);
    chk("b_release", rel_b,   exp_rel[1]);
  endtask

  // One clock edge: advance the model, then sample the DUTs just after the edge.
  task automatic step();
    @(posedge clk);
    model_edge(0, raw_a);
    model_edge(1, raw_b);
    #1;
    check_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    raw_a = 4'hF;
    raw_b = 4'h0;
    model_reset();

    // Reset and idle
    steps(3);
    chk("rst_clean_a", clean_a, 4'hF);
    chk("rst_clean_b", clean_b, 4'h0);
    reset = 1'b0;
    steps(100);
    chk("idle_clean_a", clean_a, 4'hF);

    // Key 0 press: accepted on edge 10
    raw_a = 4'hE;
    steps(9);
    chk("k0_clean_e9", clean_a, 4'hF);
    step();
    chk("k0_clean_e10", clean_a, 4'hE);
    chk("k0_press_e10", press_a, 4'h1);
    chk("k0_rel_e10",   rel_a,   4'h0);
    step();
    chk("k0_press_e11", press_a, 4'h0);

    // Key 1 bounces with 3-cycle intervals, then settles low
    raw_a = 4'hC; steps(3);
    raw_a = 4'hE; steps(3);
    raw_a = 4'hC;
    steps(9);
    chk("k1_press_e9", press_a, 4'h0);
    step();
    chk("k1_press_e10", press_a, 4'h2);
    chk("k1_clean_e10", clean_a, 4'hC);
    steps(10);

    // All keys together
    raw_a = 4'hF; steps(15);
    raw_a = 4'h0;
    steps(10);
    chk("all_press", press_a, 4'hF);
    step();
    chk("all_clean_low", clean_a, 4'h0);
    steps(4);
    raw_a = 4'hF;
    steps(10);
    chk("all_release", rel_a,   4'hF);
    chk("all_clean_hi", clean_a, 4'hF);
    steps(5);

    // Reset in the middle of a key-2 count while key 0 is already accepted
    raw_a = 4'hE; steps(12);
    chk("pre_rst_clean", clean_a, 4'hE);
    raw_a = 4'hA; steps(7);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_clean", clean_a, 4'hF);
    chk("async_rst_press", press_a, 4'h0);
    steps(2);
    reset = 1'b0;
    steps(9);
    chk("post_rst_e9", press_a, 4'h0);
    step();
    chk("post_rst_press_e10", press_a, 4'h5);
    chk("post_rst_rel_e10",   rel_a,   4'h0);
    chk("post_rst_clean_e10", clean_a, 4'hA);
    steps(3);

    // Active-high instance: key 3 press
    raw_b = 4'h8;
    steps(10);
    chk("ah_press_e10", press_b, 4'h8);
    chk("ah_clean_e10", clean_b, 4'h8);
    steps(3);

    // Randomised stretches of held and bouncing inputs on both instances
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) raw_a = 4'($urandom);
      if ($urandom_range(0, 5) == 0) raw_b = 4'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_system_key_debounce.md
# audio_system_key_debounce

Debounces the four DE10-Standard push-buttons before they reach the key PIO input port. Each raw key input is synchronised into `clk`, then filtered by a per-key stability counter. The block drives a clean level vector for the PIO and emits single-cycle press/release strobes for local control logic such as volume step and mute toggle.

## Interface
Parameters:
- `WIDTH`, 4: number of keys.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a change (20 ms at 50 MHz). Must be ≥ 1.
- `ACTIVE_LOW`, 1: 1 = key pressed when input is 0 (DE10 KEY polarity); 0 = pressed when input is 1.

Ports:
- `clk` in 1: system clock; one clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `keys_raw` in WIDTH: asynchronous raw button inputs from pins.
- `keys_clean` out WIDTH: debounced levels, same polarity as `keys_raw`; feeds the PIO `in_port`.
- `press_pulse` out WIDTH: one-cycle strobe per key when `keys_clean` enters the pressed level.
- `release_pulse` out WIDTH: one-cycle strobe per key when `keys_clean` enters the released level.

## Operation
- Per key, two-flop synchroniser `sync1 -> sync2`. All keys are fully independent.
- Per-key state is `stable` (drives `keys_clean`) and counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
- Each cycle, per key:
  - `sync2 == stable`: `cnt <= 0`. Any bounce restarts the count.
  - `sync2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `sync2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`, and fire the matching pulse.
- Pressed level is `~ACTIVE_LOW`, released level is `ACTIVE_LOW`.
  - Entering the pressed level sets `press_pulse[i]`.
  - Entering the released level sets `release_pulse[i]`.
  - The two pulses are never high together for the same key.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.
- Reset values:
  - `sync1`, `sync2`, `stable` = released level. `keys_clean` = all `ACTIVE_LOW`, i.e. 4'hF by default.
  - `cnt` = 0.
  - `press_pulse` and `release_pulse` = 0.
- A key held pressed through reset release is reported as one press after the normal latency. There is no spurious release strobe.
- Reset asserted mid-count discards the count. Outputs take their reset values immediately, asynchronously.

## Timing
- Latency: if `keys_raw[i]` changes and then holds steady, `keys_clean[i]` and the pulse update on edge `DEBOUNCE_CYCLES+2`, counting the first edge that samples the new value as edge 1.
  - 2 edges are synchroniser.
  - `DEBOUNCE_CYCLES` edges are counting.
- Pulses are registered and exactly one cycle wide. They are asserted in the same cycle `keys_clean` first shows the new level.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles, measured at `sync2`, never changes `keys_clean` and never fires a pulse.
- Simultaneous changes on several keys are handled independently. Multiple pulse bits may be high in the same cycle.
- All outputs are registered, with no combinational path from `keys_raw`.

## Structure
- Sub-module `audio_system_key_debounce_cell`: single-bit synchroniser, counter, stable register and pulse generation. The top instantiates it `WIDTH` times in a generate loop.
- Shared package `audio_system_key_pkg`:
  - `KEY_DEBOUNCE_CYCLES_DEFAULT` = 1000000.
  - `KEY_WIDTH_DEFAULT` = 4.
  - A counter-width function.
- No other shared typedefs.

## Test plan
Benches use `DEBOUNCE_CYCLES`=8 and `ACTIVE_LOW`=1 unless stated.
- Reset then idle with `keys_raw`=4'hF: `keys_clean`=4'hF, and both pulse vectors stay 0 for 100 cycles.
- `keys_raw[0]` goes 1→0 and holds: `keys_clean`=4'hE and `press_pulse`=4'h1 for one cycle on edge 10. `release_pulse` stays 0.
- `keys_raw[1]` bounces 0/1/0 at 3-cycle intervals, then settles at 0: no output change until 10 edges after the last transition. Then exactly one `press_pulse[1]`.
- `keys_raw` 4'hF→4'h0 together, held, then back to 4'hF and held:
  - `press_pulse`=4'hF in one cycle, then `keys_clean`=4'h0.
  - Later `release_pulse`=4'hF in one cycle and `keys_clean`=4'hF.
- Reset asserted at count 5 of a key-2 press:
  - `keys_clean` returns to 4'hF asynchronously.
  - After reset release with the key still low, `press_pulse[2]` fires on edge 10 after the release.
- `ACTIVE_LOW`=0, `keys_raw[3]` 0→1 held: `press_pulse[3]` on edge 10 and `keys_clean`=4'h8.
